// File: rtl/crc_frame_tx_ctrl.sv
// rtl/crc_frame_tx_ctrl.sv - transmit frame sequencer driving a byte-wide CRC-32 generator
module crc_frame_tx_ctrl #(
   parameter int unsigned MIN_LEN    = 60,
   parameter logic [7:0]  PAD_BYTE   = 8'h00,
   parameter int unsigned IFG_CYCLES = 12,
   parameter int unsigned LEN_W      = 16
) (
   input  logic       Clk,
   input  logic       Reset,
   input  logic       Ce,
   input  logic [7:0] Src_data,
   input  logic       Src_valid,
   input  logic       Src_last,
   output logic       Src_ready,
   output logic       Crc_init,
   output logic [7:0] Crc_data,
   output logic       Crc_data_en,
   output logic       Crc_rd,
   input  logic [7:0] Crc_out,
   input  logic       Crc_end,
   output logic [7:0] Tx_data,
   output logic       Tx_valid,
   output logic       Tx_last,
   output logic       Tx_err,
   output logic       Busy
);

   localparam int unsigned       IFG_W     = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;
   localparam logic [IFG_W-1:0]  IFG_LAST  = IFG_W'(IFG_CYCLES - 1);
   localparam logic [LEN_W:0]    MIN_LEN_X = (LEN_W+1)'(MIN_LEN);

   typedef enum logic [2:0] {
      S_IDLE, S_INIT, S_DATA, S_PAD, S_FCS, S_IFG
   } state_t;

   state_t             state_q, state_d;
   logic [LEN_W-1:0]   len_q, len_d, len_inc;
   logic [LEN_W:0]     len_p1;
   logic [IFG_W-1:0]   ifg_q, ifg_d;
   logic [7:0]         tx_data_d;
   logic               tx_valid_d, tx_last_d, tx_err_d;

   // Byte counter: saturating increment, plus an unsaturated +1 for the pad-length compare
   always_comb begin
      len_p1  = {1'b0, len_q} + (LEN_W+1)'(1);
      len_inc = (&len_q) ? len_q : len_q + 1'b1;
   end

   // Next-state, generator strobes and next Tx register values
   always_comb begin
      state_d     = state_q;
      len_d       = len_q;
      ifg_d       = ifg_q;
      tx_data_d   = Tx_data;
      tx_valid_d  = 1'b0;
      tx_last_d   = 1'b0;
      tx_err_d    = 1'b0;
      Src_ready   = 1'b0;
      Crc_init    = 1'b0;
      Crc_data    = Src_data;
      Crc_data_en = 1'b0;
      Crc_rd      = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (Ce && Src_valid) state_d = S_INIT;
         end
         S_INIT: begin
            Crc_init = 1'b1;
            if (Ce) begin
               len_d   = '0;
               state_d = S_DATA;
            end
         end
         S_DATA: begin
            Src_ready   = Ce;
            Crc_data_en = Src_valid;
            if (Ce) begin
               if (Src_valid) begin
                  tx_data_d  = Src_data;
                  tx_valid_d = 1'b1;
                  len_d      = len_inc;
                  if (Src_last) state_d = (len_p1 < MIN_LEN_X) ? S_PAD : S_FCS;
               end else begin
                  // Underrun: abandon the frame without an FCS
                  tx_err_d = 1'b1;
                  ifg_d    = '0;
                  state_d  = S_IFG;
               end
            end
         end
         S_PAD: begin
            Crc_data    = PAD_BYTE;
            Crc_data_en = 1'b1;
            if (Ce) begin
               tx_data_d  = PAD_BYTE;
               tx_valid_d = 1'b1;
               len_d      = len_inc;
               if (len_p1 == MIN_LEN_X) state_d = S_FCS;
            end
         end
         S_FCS: begin
            // Held from state so the generator's byte index never resets mid-FCS
            Crc_rd = 1'b1;
            if (Ce) begin
               tx_data_d  = Crc_out;
               tx_valid_d = 1'b1;
               if (Crc_end) begin
                  tx_last_d = 1'b1;
                  ifg_d     = '0;
                  state_d   = S_IFG;
               end
            end
         end
         S_IFG: begin
            if (Ce) begin
               if (ifg_q == IFG_LAST) state_d = S_IDLE;
               else                   ifg_d   = ifg_q + 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
      if (Reset) begin
         Src_ready   = 1'b0;
         Crc_init    = 1'b0;
         Crc_data_en = 1'b0;
         Crc_rd      = 1'b0;
      end
   end

   // State, counters and registered Tx outputs
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q  <= S_IDLE;
         len_q    <= '0;
         ifg_q    <= '0;
         Tx_data  <= 8'h00;
         Tx_valid <= 1'b0;
         Tx_last  <= 1'b0;
         Tx_err   <= 1'b0;
      end else begin
         state_q  <= state_d;
         len_q    <= len_d;
         ifg_q    <= ifg_d;
         Tx_data  <= tx_data_d;
         Tx_valid <= tx_valid_d;
         Tx_last  <= tx_last_d;
         Tx_err   <= tx_err_d;
      end
   end

   assign Busy = (state_q != S_IDLE);

endmodule

// File: tb/tb_crc_frame_tx_ctrl.sv
// tb/tb_crc_frame_tx_ctrl.sv - self-checking bench for crc_frame_tx_ctrl
module tb_crc_frame_tx_ctrl;

   localparam int IFG = 12;
   localparam int MINS [2] = '{0, 60};

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst = 1'b1;
   logic       ce = 1'b1;
   logic [7:0] src_data = 8'h00;
   logic       src_valid_drv = 1'b0;
   logic       src_last = 1'b0;
   int         sel = 0;
   int         ce_mode = 0;

   logic [1:0] src_ready, crc_init, crc_en, crc_rd, crc_end, tx_valid, tx_last, tx_err, busy;
   logic [7:0] crc_data [2];
   logic [7:0] crc_out  [2];
   logic [7:0] tx_data  [2];

   int total = 0;
   int bad   = 0;

   function automatic logic [31:0] crc32_byte(input logic [31:0] c, input logic [7:0] d);
      logic [31:0] r;
      r = c ^ {24'h0, d};
      for (int k = 0; k < 8; k++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
      return r;
   endfunction

   // Instance 0: no padding; instance 1: 60-byte minimum. Each has a behavioural generator.
   for (genvar g = 0; g < 2; g++) begin : g_inst
      logic [31:0] gcrc;
      logic [31:0] gfcs;
      logic [1:0]  grd;

      crc_frame_tx_ctrl #(
         .MIN_LEN(g == 0 ? 0 : 60), .PAD_BYTE(8'h00), .IFG_CYCLES(IFG), .LEN_W(16)
      ) u_dut (
         .Clk(clk), .Reset(rst), .Ce(ce),
         .Src_data(src_data), .Src_valid(src_valid_drv && (sel == g)), .Src_last(src_last),
         .Src_ready(src_ready[g]),
         .Crc_init(crc_init[g]), .Crc_data(crc_data[g]), .Crc_data_en(crc_en[g]), .Crc_rd(crc_rd[g]),
         .Crc_out(crc_out[g]), .Crc_end(crc_end[g]),
         .Tx_data(tx_data[g]), .Tx_valid(tx_valid[g]), .Tx_last(tx_last[g]), .Tx_err(tx_err[g]),
         .Busy(busy[g])
      );

      always @(posedge clk) begin
         if (ce && crc_init[g])    gcrc <= 32'hFFFFFFFF;
         else if (ce && crc_en[g]) gcrc <= crc32_byte(gcrc, crc_data[g]);
         if (rst || !crc_rd[g])    grd <= 2'd0;
         else if (ce)              grd <= grd + 2'd1;
      end
      assign gfcs       = ~gcrc;
      assign crc_out[g] = gfcs[8*grd +: 8];
      assign crc_end[g] = crc_rd[g] && (grd == 2'd3);
   end

   // Monitor of the selected instance
   logic [8:0] got_q [$];
   logic [8:0] exp_q [$];
   logic [8:0] tmp_q [$];
   logic [7:0] pay   [$];
   int  err_cnt, rd_rise, ce_viol, cyc, last_cyc, gap_seen;
   bit  last_pending, rd_prev, ce_at_edge;

   always @(posedge clk) ce_at_edge <= ce;

   always @(negedge clk) begin
      cyc++;
      if (tx_valid[sel]) begin
         got_q.push_back({tx_last[sel], tx_data[sel]});
         if (!ce_at_edge) ce_viol++;
         if (last_pending) begin
            gap_seen     = cyc - last_cyc - 1;
            last_pending = 0;
         end
         if (tx_last[sel]) begin
            last_cyc     = cyc;
            last_pending = 1;
         end
      end
      if (tx_err[sel]) err_cnt++;
      if (crc_rd[sel] && !rd_prev) rd_rise++;
      rd_prev = crc_rd[sel];
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      case (ce_mode)
         0:       ce = 1'b1;
         1:       ce = ~ce;
         default: ce = ($urandom_range(0, 3) != 0);
      endcase
   endtask

   task automatic clr();
      got_q.delete();
      err_cnt = 0; rd_rise = 0; ce_viol = 0;
      last_pending = 0; gap_seen = -1;
   endtask

   task automatic fill_pay(input int n, input bit ascii);
      pay.delete();
      for (int i = 0; i < n; i++) pay.push_back(ascii ? 8'(8'h31 + i) : 8'($urandom));
   endtask

   // Expected frame: payload, zero pad to minlen, CRC-32 of all of it sent LSB first
   task automatic model(input int minlen, input int n, input int stall);
      logic [31:0] c;
      logic [7:0]  b;
      exp_q.delete();
      if (stall >= 0) begin
         for (int i = 0; i < stall; i++) exp_q.push_back({1'b0, pay[i]});
         return;
      end
      c = 32'hFFFFFFFF;
      for (int i = 0; i < n || i < minlen; i++) begin
         b = (i < n) ? pay[i] : 8'h00;
         c = crc32_byte(c, b);
         exp_q.push_back({1'b0, b});
      end
      c = ~c;
      for (int k = 0; k < 4; k++) exp_q.push_back({k == 3, c[8*k +: 8]});
   endtask

   task automatic send_frame(input int n, input int stall);
      int i = 0;
      int guard = 0;
      while (i < n) begin
         tick();
         if (i == stall) begin
            src_valid_drv = 1'b0;
            return;
         end
         src_data = pay[i]; src_last = (i == n - 1); src_valid_drv = 1'b1;
         #1;
         if (ce && src_ready[sel]) begin
            i++;
            guard = 0;
         end else if (++guard > 200) begin
            total++; bad++;
            $display("FAIL src_timeout byte=%0d actual=no_ready required=ready", i);
            src_valid_drv = 1'b0;
            return;
         end
      end
   endtask

   task automatic wait_idle();
      int guard = 0;
      tick();
      src_valid_drv = 1'b0; src_last = 1'b0;
      while (busy[sel]) begin
         tick();
         if (++guard > 3000) begin
            total++; bad++;
            $display("FAIL idle_timeout actual=busy required=idle");
            return;
         end
      end
   endtask

   task automatic check_frame(input string tag, input int exp_n, input int exp_err, input int exp_rd);
      int n;
      check({tag, "_count"}, got_q.size(), exp_n);
      check({tag, "_err"}, err_cnt, exp_err);
      check({tag, "_crcrd_rise"}, rd_rise, exp_rd);
      check({tag, "_ce_gate"}, ce_viol, 0);
      n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
      for (int i = 0; i < n; i++) check($sformatf("%s_byte%0d", tag, i), got_q[i], exp_q[i]);
   endtask

   typedef struct {
      int inst; int len; int ce_mode; int stall; bit ascii; int exp_n; int exp_err;
   } vec_t;
   vec_t vecs [12];
   logic [7:0] kat [4];

   initial begin
      vecs[0]  = '{0,  9, 0, -1, 1, 13, 0};
      vecs[1]  = '{1, 10, 0, -1, 0, 64, 0};
      vecs[2]  = '{0,  9, 1, -1, 1, 13, 0};
      vecs[3]  = '{1, 10, 1, -1, 0, 64, 0};
      vecs[4]  = '{1, 20, 0,  5, 0,  5, 1};
      vecs[5]  = '{1, 20, 0, -1, 0, 64, 0};
      vecs[6]  = '{0,  1, 0, -1, 0,  5, 0};
      vecs[7]  = '{1, 60, 0, -1, 0, 64, 0};
      vecs[8]  = '{1, 61, 1, -1, 0, 65, 0};
      vecs[9]  = '{1, 59, 2, -1, 0, 64, 0};
      vecs[10] = '{0, 20, 2,  4, 0,  4, 1};
      vecs[11] = '{1,  1, 0, -1, 0, 64, 0};
      kat = '{8'h26, 8'h39, 8'hF4, 8'hCB};
      clr();

      repeat (3) tick();
      for (int g = 0; g < 2; g++)
         check($sformatf("reset_state%0d", g),
               {tx_data[g], tx_valid[g], tx_last[g], tx_err[g], busy[g],
                crc_init[g], crc_en[g], crc_rd[g], src_ready[g]}, 0);
      rst = 1'b0;
      tick();
      clr();

      for (int r = 0; r < 12; r++) begin
         sel = vecs[r].inst; ce_mode = vecs[r].ce_mode;
         fill_pay(vecs[r].len, vecs[r].ascii);
         model(MINS[sel], vecs[r].len, vecs[r].stall);
         clr();
         send_frame(vecs[r].len, vecs[r].stall);
         wait_idle();
         check_frame($sformatf("vec%0d", r), vecs[r].exp_n, vecs[r].exp_err, (vecs[r].stall >= 0) ? 0 : 1);
         if (vecs[r].ascii && got_q.size() == 13)
            for (int k = 0; k < 4; k++)
               check($sformatf("vec%0d_kat%0d", r, k), got_q[9+k], {k == 3, kat[k]});
      end

      for (int r = 0; r < 8; r++) begin
         int n;
         sel = $urandom_range(0, 1); ce_mode = 2; n = $urandom_range(1, 70);
         fill_pay(n, 0);
         model(MINS[sel], n, -1);
         clr();
         send_frame(n, -1);
         wait_idle();
         check_frame($sformatf("rnd%0d", r), exp_q.size(), 0, 1);
      end

      // Back-to-back frames with the source never idle
      sel = 1; ce_mode = 0;
      clr();
      fill_pay(12, 0); model(60, 12, -1); tmp_q = exp_q;
      send_frame(12, -1);
      fill_pay(3, 0); model(60, 3, -1); exp_q = {tmp_q, exp_q};
      send_frame(3, -1);
      wait_idle();
      check_frame("b2b", 128, 0, 2);
      check("b2b_gap", gap_seen, IFG + 2);

      // Reset in the middle of the FCS
      sel = 0; ce_mode = 0;
      clr();
      fill_pay(9, 1);
      send_frame(9, -1);
      begin
         int guard = 0;
         tick();
         src_valid_drv = 1'b0; src_last = 1'b0;
         while (got_q.size() < 11 && guard < 100) begin
            tick();
            guard++;
         end
         check("rst_fcs_reached", guard < 100, 1);
      end
      rst = 1'b1;
      #1;
      check("rst_comb_crcrd", crc_rd[0], 0);
      tick();
      check("rst_mid_out", {tx_data[0], tx_valid[0], tx_last[0], tx_err[0], busy[0],
                            crc_init[0], crc_en[0], crc_rd[0], src_ready[0]}, 0);
      tick();
      rst = 1'b0;
      tick();
      fill_pay(9, 1); model(0, 9, -1);
      clr();
      send_frame(9, -1);
      wait_idle();
      check_frame("post_rst", 13, 0, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
